// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_pkg
// Brief   : Shared constants, types and address decode for the RAM hierarchy
//           (ram8, ram64, ram512).
// Rev     : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int WORD_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // One-hot decode of a 3-bit word address (DMux8Way select pattern).
  function automatic logic [DEPTH-1:0] onehot8(input addr_t a);
    logic [DEPTH-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register16.sv
`default_nettype none
// ============================================================================
// Module  : register16
// Brief   : 16-bit register with load enable and asynchronous active-low
//           clear to zero.
// Rev     : 1.0 - initial release
// ============================================================================
module register16
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t in,
  output word_t out
);

  word_t r_q;

  // Capture in on a load edge; async clear dominates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (load) r_q <= in;
  end

  assign out = r_q;

endmodule
`default_nettype wire

// File: rtl/ram8.sv
`default_nettype none
// ============================================================================
// Module  : ram8
// Brief   : 8 x 16-bit memory, synchronous write through a one-hot decode,
//           combinational read through an 8:1 mux, plus a sticky per-word
//           written mask.
//           Optional macro RAM8_BYPASS_EN: write-through read (out = in while
//           load is high); storage timing is unaffected.
// Rev     : 1.0 - initial release
// ============================================================================
module ram8
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] in,
  output logic [WORD_W-1:0] out,
  output logic [DEPTH-1:0]  written
);

  logic [DEPTH-1:0] w_sel;
  word_t            w_words [DEPTH];
  word_t            w_stored;
  logic [DEPTH-1:0] r_written;

  // Per-word load strobes: at most one is high, and only while load is set.
  always_comb begin
    w_sel = '0;
    if (load) w_sel = onehot8(address);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_word
      register16 u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_sel[gi]),
        .in    (in),
        .out   (w_words[gi])
      );
    end
  endgenerate

  // Read mux: current address selects one stored word.
  always_comb begin
    w_stored = w_words[address];
  end

`ifdef RAM8_BYPASS_EN
  // Write-through: the word being written appears on out in the same cycle.
  // Gated by rst_n so out stays zero while the block is held in reset.
  always_comb begin
    out = w_stored;
    if (load && rst_n) out = in;
  end
`else
  // Stored contents only; a write shows up the cycle after its edge.
  always_comb begin
    out = w_stored;
  end
`endif

  // Sticky written mask; bits only ever set, cleared solely by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_written <= '0;
    else        r_written <= r_written | w_sel;
  end

  assign written = r_written;

`ifndef SYNTHESIS
  // A write to an unknown address would corrupt an unpredictable word.
  always_ff @(posedge clk) begin
    if (rst_n && load) assert (!$isunknown(address));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram8.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram8
// Brief   : Self-checking bench for ram8: reference memory model, per-cycle
//           comparison, and directed vectors with literal expectations.
//           Honors RAM8_BYPASS_EN when the design is built with it.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ram8;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic [15:0] out;
  logic [7:0]  written;

  int checks;
  int failures;

  logic [15:0] mdl_mem [8];
  logic [7:0]  mdl_mask;

  ram8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out),
    .written (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: an array written at the edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mdl_mem[k] = 16'h0000;
      mdl_mask = 8'h00;
    end else if (load) begin
      mdl_mem[address] = in;
      mdl_mask[address] = 1'b1;
    end
  end

  function automatic logic [15:0] mdl_out();
`ifdef RAM8_BYPASS_EN
    if (load && rst_n) return in;
`endif
    return mdl_mem[address];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (out !== mdl_out()) begin
      failures++;
      $display("FAIL model_out t=%0t addr=%0d actual=%h required=%h", $time, address, out, mdl_out());
    end
    checks++;
    if (written !== mdl_mask) begin
      failures++;
      $display("FAIL model_written t=%0t actual=%h required=%h", $time, written, mdl_mask);
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read one address with load low and compare against a literal.
  task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    load = 1'b0;
    address = a;
    #2;
    chk16(name, out, exp);
    step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    load = 1'b1;
    address = a;
    in = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    load = 1'b0;
    address = 3'd0;
    in = 16'h0000;
    step();
    step();
    rst_n = 1'b1;
    step();

    // After reset everything reads zero.
    for (int i = 0; i < 8; i++) rd("reset_read", 3'(i), 16'h0000);
    chk8("reset_written", written, 8'h00);

    // Single write, neighbours untouched.
    wr(3'd3, 16'hBEEF);
    rd("w3_read3", 3'd3, 16'hBEEF);
    chk8("w3_written", written, 8'h08);
    rd("w3_read2", 3'd2, 16'h0000);
    rd("w3_read4", 3'd4, 16'h0000);

    // Fill all words, then read back.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) rd("fill_read", 3'(i), 16'h1000 + 16'(i));
    chk8("fill_written", written, 8'hFF);

    // Rewrite word 0; others hold, mask stays full.
    wr(3'd0, 16'hFFFF);
    rd("rewrite_w0", 3'd0, 16'hFFFF);
    for (int i = 1; i < 8; i++) rd("rewrite_others", 3'(i), 16'h1000 + 16'(i));
    chk8("rewrite_written", written, 8'hFF);

    // Back-to-back writes to the same word: last wins.
    load = 1'b1; address = 3'd7; in = 16'h1111; step();
    in = 16'h2222; step();
    load = 1'b0;
    rd("last_wins", 3'd7, 16'h2222);

    // Address moves from 2 to 6 as load rises: only word 6 is written.
    load = 1'b0; address = 3'd2; in = 16'h5555; step();
    wr(3'd6, 16'hA5A5);
    rd("addr_change_w6", 3'd6, 16'hA5A5);
    rd("addr_change_w2", 3'd2, 16'h1002);

    // Reset asserted mid-write: reset dominates, nothing lands afterwards.
    load = 1'b1; address = 3'd5; in = 16'h1234;
    #2 rst_n = 1'b0;
    #1 load = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) rd("midreset_read", 3'(i), 16'h0000);
    chk8("midreset_written", written, 8'h00);

    // Write-through behaviour before the edge, stored value after it.
    load = 1'b1; address = 3'd1; in = 16'h00FF;
    #2;
`ifdef RAM8_BYPASS_EN
    chk16("bypass_pre_edge", out, 16'h00FF);
`else
    chk16("nobypass_pre_edge", out, 16'h0000);
`endif
    step();
    load = 1'b0;
    rd("post_edge", 3'd1, 16'h00FF);
    chk8("post_edge_written", written, 8'h02);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
